// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into registered pulses of programmable width
// followed by a dead time; strobes arriving while busy are dropped and counted.
module pulse_stretcher #(
  parameter int LEN_BITS  = 8,
  parameter int DEAD_BITS = 8,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 strobe,
  input  logic [LEN_BITS-1:0]  pulse_len,
  input  logic [DEAD_BITS-1:0] dead_len,
  input  logic                 clear_missed,
  output logic                 pulse_out,
  output logic                 busy,
  output logic [CNT_BITS-1:0]  missed_cnt
);

  localparam int CW = (LEN_BITS > DEAD_BITS) ? LEN_BITS : DEAD_BITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_DEAD  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DEAD_BITS-1:0] dead_q, dead_d;
  logic                 accept;
  logic                 miss;
  logic                 sat;

  assign accept = (state_q == S_IDLE) && strobe
               && enable && (pulse_len != '0);
  assign miss   = strobe && busy;
  assign sat    = &missed_cnt;

  // cnt holds the cycles remaining in the current phase after this one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dead_d  = dead_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_PULSE;
          cnt_d   = CW'(pulse_len) - CW'(1);
          dead_d  = dead_len;
        end
      end
      S_PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (dead_q != '0) begin
          state_d = S_DEAD;
          cnt_d   = CW'(dead_q) - CW'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DEAD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dead_q     <= '0;
      pulse_out  <= 1'b0;
      busy       <= 1'b0;
      missed_cnt <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dead_q    <= dead_d;
      pulse_out <= (state_d == S_PULSE);
      busy      <= (state_d != S_IDLE);
      if (clear_missed) begin
        missed_cnt <= miss ? CNT_BITS'(1) : '0;
      end else if (miss && !sat) begin
        missed_cnt <= missed_cnt + CNT_BITS'(1);
      end
    end
  end

endmodule
